// File: rtl/hilo_seq.sv
// Multiply/divide sequencer with architectural HI/LO registers.
// Latches operands, clears and runs the selected iterative unit, then captures its result.
module hilo_seq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             unit_clr,
  output logic             mult_run,
  output logic             div_run,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_sel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CLR, RUN, CAPT} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             op_div, op_div_d;
  logic [WIDTH-1:0] op_a_d, op_b_d, hi_d, lo_d;
  logic             unit_clr_d, mult_run_d, div_run_d, busy_d, done_d, div_zero_d;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      hi       <= '0;
      lo       <= '0;
      unit_clr <= 1'b0;
      mult_run <= 1'b0;
      div_run  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      op_div   <= op_div_d;
      op_a     <= op_a_d;
      op_b     <= op_b_d;
      hi       <= hi_d;
      lo       <= lo_d;
      unit_clr <= unit_clr_d;
      mult_run <= mult_run_d;
      div_run  <= div_run_d;
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= div_zero_d;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with it
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    op_div_d   = op_div;
    op_a_d     = op_a;
    op_b_d     = op_b;
    hi_d       = hi;
    lo_d       = lo;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state)
      IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start_mult) begin
          op_a_d   = a_in;
          op_b_d   = b_in;
          op_div_d = 1'b0;
          state_d  = CLR;
        end else if (start_div) begin
          if (b_in != '0) begin
            op_a_d   = a_in;
            op_b_d   = b_in;
            op_div_d = 1'b1;
            state_d  = CLR;
          end else begin
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end
        end
      end
      CLR: begin
        cnt_d   = op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        state_d = RUN;
      end
      RUN: begin
        // Counter holds the remaining RUN cycles including this one; saturates at 0
        cnt_d = (cnt != '0) ? cnt - CNT_W'(1) : '0;
        if (cnt <= CNT_W'(1)) state_d = CAPT;
      end
      CAPT: begin
        hi_d    = op_div ? div_hi : mult_hi;
        lo_d    = op_div ? div_lo : mult_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    unit_clr_d = (state_d == CLR);
    mult_run_d = (state_d == RUN) && !op_div_d;
    div_run_d  = (state_d == RUN) && op_div_d;
    busy_d     = (state_d != IDLE);
  end

  assign rdata = hilo_sel ? hi : lo;

endmodule

// File: tb/tb_hilo_seq.sv
// Self-checking bench for hilo_seq: behavioural iterative units plus an
// arithmetic reference for HI/LO, latency and enable counts.
module tb_hilo_seq;

  localparam int unsigned W = 32;
  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_mult, start_div, mthi, mtlo, hilo_sel;
  logic [W-1:0] a_in, b_in, wdata;
  logic [W-1:0] op_a, op_b, mult_hi, mult_lo, div_hi, div_lo, hi, lo, rdata;
  logic         unit_clr, mult_run, div_run, busy, done, div_zero;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  always #5 clk = ~clk;

  hilo_seq #(.WIDTH(W), .MULT_CYCLES(N), .DIV_CYCLES(N)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a_in(a_in), .b_in(b_in), .op_a(op_a), .op_b(op_b), .unit_clr(unit_clr),
    .mult_run(mult_run), .div_run(div_run), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo), .busy(busy), .done(done), .div_zero(div_zero),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hilo_sel(hilo_sel),
    .hi(hi), .lo(lo), .rdata(rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  // Returns {remainder, quotient}, truncating toward zero
  function automatic logic [63:0] div_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) return 64'hDEAD_0000_DEAD_0000;
    if (a == 32'h8000_0000 && sb == -1) return {32'h0, a};
    q = sa / sb;
    r = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  // Behavioural units: result is valid only after exactly N enabled cycles since clear
  int mcnt, dcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt <= 0;
      dcnt <= 0;
    end else if (unit_clr) begin
      mcnt <= 0;
      dcnt <= 0;
    end else begin
      if (mult_run) mcnt <= mcnt + 1;
      if (div_run)  dcnt <= dcnt + 1;
    end
  end

  always_comb begin
    logic [63:0] mp, dq;
    mp = mul_ref(op_a, op_b);
    dq = div_ref(op_a, op_b);
    mult_hi = (mcnt == int'(N)) ? mp[63:32] : 32'hA5A5_A5A5;
    mult_lo = (mcnt == int'(N)) ? mp[31:0]  : 32'h5A5A_5A5A;
    div_hi  = (dcnt == int'(N)) ? dq[63:32] : 32'hC3C3_C3C3;
    div_lo  = (dcnt == int'(N)) ? dq[31:0]  : 32'h3C3C_3C3C;
  end

  // Issue one operation at the current negedge and follow it to done.
  // inject > 0 pulses start_div and mthi (0xDEADBEEF) during that busy cycle.
  task automatic run_op(input string tag, input bit is_div, input bit both,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int inject);
    int lat = 0, runs = 0, other = 0, busys = 0, clrs = 0;
    logic [63:0] res;
    start_mult = !is_div || both;
    start_div  = is_div || both;
    a_in = a;
    b_in = b;
    res = (is_div && !both) ? div_ref(a, b) : mul_ref(a, b);
    {exp_hi, exp_lo} = res;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start_mult = 1'b0;
      start_div  = 1'b0;
      mthi       = 1'b0;
      a_in       = $urandom;
      b_in       = $urandom;
      runs  += (is_div && !both) ? int'(div_run) : int'(mult_run);
      other += (is_div && !both) ? int'(mult_run) : int'(div_run);
      busys += int'(busy);
      clrs  += int'(unit_clr);
      if (done) begin
        lat = i;
        break;
      end
      if (i == inject) begin
        start_div = 1'b1;
        b_in      = 32'd1;
        mthi      = 1'b1;
        wdata     = 32'hDEAD_BEEF;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(N + 3));
    check({tag, "_run_cycles"}, 64'(runs), 64'(N));
    check({tag, "_other_run"}, 64'(other), 64'(0));
    check({tag, "_busy_cycles"}, 64'(busys), 64'(N + 2));
    check({tag, "_clr_pulses"}, 64'(clrs), 64'(1));
    check({tag, "_div_zero"}, 64'(div_zero), 64'(0));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  task automatic write_hilo(input bit wh, input bit wl, input logic [W-1:0] d);
    mthi = wh;
    mtlo = wl;
    wdata = d;
    if (wh) exp_hi = d;
    if (wl) exp_lo = d;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    hilo_sel = 1'b1;
    #1 check("rdata_hi", 64'(rdata), 64'(exp_hi));
    hilo_sel = 1'b0;
    #1 check("rdata_lo", 64'(rdata), 64'(exp_lo));
    @(negedge clk);
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    reset = 1'b1;
    {start_mult, start_div, mthi, mtlo, hilo_sel} = '0;
    a_in = '0; b_in = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_hi_lo", {hi, lo}, 64'h0);
    check("rst_ctrl", 64'({busy, done, div_zero, unit_clr, mult_run, div_run}), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul_7_m3", 0, 0, 32'd7, 32'hFFFF_FFFD, 0);
    check("mul_7_m3_hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("mul_7_m3_lo_const", 64'(lo), 64'hFFFF_FFEB);
    run_op("b2b_3x4", 0, 0, 32'd3, 32'd4, 0);
    check("b2b_lo_const", 64'(lo), 64'd12);

    @(negedge clk);
    run_op("div_100_7", 1, 0, 32'd100, 32'd7, 0);
    check("div_hi_const", 64'(hi), 64'd2);
    check("div_lo_const", 64'(lo), 64'd14);

    // Divide by zero: immediate done/div_zero, HI/LO untouched, never busy
    @(negedge clk);
    start_div = 1'b1; a_in = 32'd55; b_in = 32'd0;
    @(negedge clk);
    start_div = 1'b0;
    check("dz_done", 64'({done, div_zero, busy, div_run, unit_clr}), 64'b11000);
    check("dz_hilo", {hi, lo}, {32'd2, 32'd14});
    @(negedge clk);
    check("dz_after", 64'({done, div_zero, busy}), 64'b000);

    // Asynchronous reset in RUN cycle 10
    start_mult = 1'b1; a_in = 32'd9; b_in = 32'd9;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      start_mult = 1'b0;
    end
    check("pre_rst_running", 64'(mult_run), 64'd1);
    #2 reset = 1'b1;
    #1 check("arst_outputs", 64'({busy, done, div_zero, unit_clr, mult_run, div_run}), 64'h0);
    check("arst_regs", {hi, lo}, 64'h0);
    check("arst_ops", {op_a, op_b}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      dones += int'(done) + int'(busy);
    end
    check("post_rst_idle", 64'(dones), 64'd0);
    run_op("mul_big", 0, 0, 32'h0001_0000, 32'h0001_0000, 0);
    check("mul_big_const", {hi, lo}, {32'd1, 32'd0});

    @(negedge clk);
    run_op("both_5_6", 0, 1, 32'd5, 32'd6, 0);
    check("both_const", {hi, lo}, {32'd0, 32'd30});

    // Start and mthi during busy are dropped; then mthi in IDLE
    @(negedge clk);
    run_op("busy_ign", 0, 0, 32'd11, 32'hFFFF_FFF0, 10);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dones += int'(busy) + int'(done) + int'(unit_clr);
    end
    check("no_second_op", 64'(dones), 64'd0);
    write_hilo(1, 0, 32'hDEAD_BEEF);

    // Randomized operations and HI/LO writes
    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == '0) rb = 32'd3;
      if (ra == 32'h8000_0000) ra = 32'h7FFF_0000;
      if ($urandom_range(0, 1) == 1) run_op("rnd_div", 1, 0, ra, rb, 0);
      else                           run_op("rnd_mul", 0, 0, ra, rb, 0);
      @(negedge clk);
      if ($urandom_range(0, 2) == 0)
        write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no end expected end by 200000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
